// File: rtl/mem_access_arbiter_pkg.sv
// Shared definitions for the two-port memory access arbiter:
// FSM state encoding and default geometry of the shared memory.
package mem_access_arbiter_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_ADDR_W = 4;

  // CLEAR walks every word writing zero; SERVE arbitrates the two requesters.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_SERVE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_access_arbiter_mem_sp_array.sv
// Single-port DEPTH x DATA_W storage: synchronous write, registered read,
// no reset. Out-of-range writes are dropped and out-of-range reads return 0.
module mem_sp_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  // Address range check is done on the full address so aliasing can't occur.
  assign in_range = ({1'b0, addr} < DEPTH_L);
  assign idx      = addr[IDX_W-1:0];

  // One access per cycle; rdata only moves on a read so it holds otherwise.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        if (in_range) mem[idx] <= wdata;
      end else begin
        rdata <= in_range ? mem[idx] : '0;
      end
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Two-requester arbiter in front of a single-port memory. After every reset
// (and on clr_start) the memory is zeroed one word per cycle; afterwards the
// two ports are served one access per cycle, alternating on contention.
//
// Handshake: reqN_valid/addr/we/wdata are held by the requester until
// reqN_valid && reqN_ready in the same cycle; the access is taken on that
// rising edge. reqN_ready is combinational and never high for both ports.
// A read accepted in cycle t yields a one-cycle rspN_valid pulse in t+1.
module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_start,
  output logic              clr_busy,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              dbg_state
);

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

  arb_state_t        state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;
  logic              last_grant;
  logic              gnt0, gnt1;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              rsp0_vld_q, rsp1_vld_q;
  logic [DATA_W-1:0] rsp0_hold, rsp1_hold;

  // Next state, clear counter, grant decision and memory port steering.
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    clr_busy    = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = clr_ptr;
    mem_wdata   = '0;
    case (state)
      ST_CLEAR: begin
        clr_busy = 1'b1;
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        if (clr_ptr == CLR_LAST) begin
          state_nxt   = ST_SERVE;
          clr_ptr_nxt = '0;
        end else begin
          clr_ptr_nxt = clr_ptr + 1'b1;
        end
      end
      ST_SERVE: begin
        if (clr_start) begin
          state_nxt = ST_CLEAR;
        end else if (req0_valid && req1_valid) begin
          // Contention: the port that did not win last time goes now.
          gnt0 = last_grant;
          gnt1 = !last_grant;
        end else begin
          gnt0 = req0_valid;
          gnt1 = req1_valid;
        end
        if (gnt0) begin
          mem_en    = 1'b1;
          mem_we    = req0_we;
          mem_addr  = req0_addr;
          mem_wdata = req0_wdata;
        end else if (gnt1) begin
          mem_en    = 1'b1;
          mem_we    = req1_we;
          mem_addr  = req1_addr;
          mem_wdata = req1_wdata;
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign dbg_state  = state;

  // State and clear pointer; reset always restarts the clear from word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  // Remember the last winner; reset value 1 lets port 0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (gnt0) begin
      last_grant <= 1'b0;
    end else if (gnt1) begin
      last_grant <= 1'b1;
    end
  end

  // Response pulse follows an accepted read by one cycle; reset drops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_vld_q <= 1'b0;
      rsp1_vld_q <= 1'b0;
    end else begin
      rsp0_vld_q <= gnt0 && !req0_we;
      rsp1_vld_q <= gnt1 && !req1_we;
    end
  end

  // Per-port copy of the last delivered word so each port's rdata holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_hold <= '0;
      rsp1_hold <= '0;
    end else begin
      if (rsp0_vld_q) rsp0_hold <= mem_rdata;
      if (rsp1_vld_q) rsp1_hold <= mem_rdata;
    end
  end

  assign rsp0_valid = rsp0_vld_q;
  assign rsp1_valid = rsp1_vld_q;
  assign rsp0_rdata = rsp0_vld_q ? mem_rdata : rsp0_hold;
  assign rsp1_rdata = rsp1_vld_q ? mem_rdata : rsp1_hold;

  mem_sp_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a response scoreboard.
module tb_mem_access_arbiter;
  import mem_access_arbiter_pkg::*;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          clr_start = 1'b0;
  logic          clr_busy;
  logic          req0_valid = 1'b0, req0_we = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          req0_ready, rsp0_valid;
  logic [DW-1:0] rsp0_rdata;
  logic          req1_valid = 1'b0, req1_we = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic          req1_ready, rsp1_valid;
  logic [DW-1:0] rsp1_rdata;
  logic          dbg_state;

  mem_access_arbiter #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_start  (clr_start),
    .clr_busy   (clr_busy),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] model [DP];
  logic [DW-1:0] exp0_q[$], exp1_q[$];
  int            cyc0_q[$], cyc1_q[$];
  logic [DW-1:0] last0 = '0, last1 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DP; i++) model[i] = '0;
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (int'(a) < DP) return model[a[3:0]];
    return '0;
  endfunction

  // Expected response lands one cycle after the accepting cycle.
  task automatic push_exp(input int p, input logic [DW-1:0] d);
    if (p == 0) begin
      exp0_q.push_back(d);
      cyc0_q.push_back(cyc + 1);
    end else begin
      exp1_q.push_back(d);
      cyc1_q.push_back(cyc + 1);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int p, input logic v, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
    end
  endtask

  task automatic do_access(input int p, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic ok;
    ok = 1'b0;
    drive(p, 1'b1, we, a, d);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if ((p == 0) ? req0_ready : req1_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept", 32'(ok), 32'd1);
    if (ok) begin
      if (!we) push_exp(p, model_read(a));
      else if (int'(a) < DP) model[a[3:0]] = d;
    end
    @(posedge clk);
    #1;
    drive(p, 1'b0, 1'b0, '0, '0);
  endtask

  // Count busy cycles until the clear ends; readies must stay low meanwhile.
  task automatic wait_clear(input int exp_n);
    int n;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (clr_busy) begin
        n++;
        check("ready_in_clear", 32'(req0_ready | req1_ready), 32'd0);
      end else begin
        break;
      end
    end
    check("clear_len", 32'(n), 32'(exp_n));
    check("state_serve", 32'(dbg_state), 32'(ST_SERVE));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [DW-1:0] d;
    int c;
    if (!rst_n) begin
      last0 = '0;
      last1 = '0;
    end else begin
      check("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
      if (rsp0_valid) begin
        if (exp0_q.size() == 0) begin
          check("rsp0_unexpected", 32'd1, 32'd0);
        end else begin
          d = exp0_q.pop_front();
          c = cyc0_q.pop_front();
          check("rsp0_rdata", 32'(rsp0_rdata), 32'(d));
          check("rsp0_cycle", 32'(cyc), 32'(c));
          last0 = d;
        end
      end else begin
        check("rsp0_hold", 32'(rsp0_rdata), 32'(last0));
      end
      if (rsp1_valid) begin
        if (exp1_q.size() == 0) begin
          check("rsp1_unexpected", 32'd1, 32'd0);
        end else begin
          d = exp1_q.pop_front();
          c = cyc1_q.pop_front();
          check("rsp1_rdata", 32'(rsp1_rdata), 32'(d));
          check("rsp1_cycle", 32'(cyc), 32'(c));
          last1 = d;
        end
      end else begin
        check("rsp1_hold", 32'(rsp1_rdata), 32'(last1));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset with both requesters asking: nothing may be granted.
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_clr_busy", 32'(clr_busy), 32'd1);
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rst_rsp0_rdata", 32'(rsp0_rdata), 32'd0);
    check("rst_rsp1_rdata", 32'(rsp1_rdata), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_CLEAR));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    wait_clear(16);

    // Both ports read continuously: port 0 first, then strict alternation.
    @(posedge clk);
    #1;
    drive(0, 1'b1, 1'b0, 5'd5, '0);
    drive(1, 1'b1, 1'b0, 5'd9, '0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("alt_ready0", 32'(req0_ready), 32'((i % 2) == 0));
      check("alt_ready1", 32'(req1_ready), 32'((i % 2) == 1));
      push_exp(i % 2, model_read((i % 2) == 0 ? 5'd5 : 5'd9));
      @(posedge clk);
      #1;
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);

    // Every word reads zero after the clear.
    for (int i = 0; i < DP; i++) do_access(i % 2, 1'b0, 5'(i), '0);

    // Write on port 0, read back on port 1 in the very next cycle.
    do_access(0, 1'b1, 5'd3, 8'hA5);
    do_access(1, 1'b0, 5'd3, '0);
    do_access(1, 1'b1, 5'd15, 8'h3C);
    do_access(0, 1'b0, 5'd15, '0);
    do_access(0, 1'b1, 5'd0, 8'h11);
    do_access(0, 1'b0, 5'd0, '0);

    // Out-of-range addresses: writes dropped, reads return zero, no aliasing.
    do_access(0, 1'b1, 5'd20, 8'h77);
    do_access(0, 1'b0, 5'd20, '0);
    do_access(0, 1'b0, 5'd4, '0);
    do_access(1, 1'b1, 5'd31, 8'hEE);
    do_access(1, 1'b0, 5'd31, '0);
    do_access(1, 1'b0, 5'd15, '0);

    // clr_start with both requesters valid: no grant, then a full clear.
    drive(0, 1'b1, 1'b0, 5'd3, '0);
    drive(1, 1'b1, 1'b0, 5'd0, '0);
    clr_start = 1'b1;
    @(negedge clk);
    check("clr_start_ready0", 32'(req0_ready), 32'd0);
    check("clr_start_ready1", 32'(req1_ready), 32'd0);
    @(posedge clk);
    #1;
    clr_start = 1'b0;
    model_clear();
    wait_clear(16);
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    do_access(1, 1'b0, 5'd3, '0);
    do_access(0, 1'b0, 5'd15, '0);

    // Reset pulse at clear step 7 restarts the whole 16-cycle clear.
    do_access(0, 1'b1, 5'd6, 8'h66);
    clr_start = 1'b1;
    @(posedge clk);
    #1;
    clr_start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midclr_busy", 32'(clr_busy), 32'd1);
    check("midclr_state", 32'(dbg_state), 32'(ST_CLEAR));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    wait_clear(16);
    @(posedge clk);
    #1;
    do_access(0, 1'b0, 5'd6, '0);

    // Reset between read acceptance and its response drops the response.
    do_access(0, 1'b1, 5'd2, 8'h5A);
    drive(0, 1'b1, 1'b0, 5'd2, '0);
    @(negedge clk);
    check("drop_accept", 32'(req0_ready), 32'd1);
    #1;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    wait_clear(16);
    @(posedge clk);
    #1;
    do_access(0, 1'b0, 5'd2, '0);

    // Let outstanding responses drain, then report.
    repeat (3) @(negedge clk);
    check("exp0_drained", 32'(exp0_q.size()), 32'd0);
    check("exp1_drained", 32'(exp1_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
